// File: rtl/tree_sum_sequencer_pkg.sv
// Shared types and constants for the tree-sum sequencer and its adder tree.
package tree_sum_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSum  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned TreeFanin = 8;
  localparam int unsigned SlotIdxW  = 3;

endpackage

// File: rtl/tree_sum_sequencer_tree_sum8.sv
// Combinational 8-operand adder tree; each level widens by one bit so the sum is exact.
module tree_sum8 #(
  parameter int unsigned N = 64
) (
  input  logic [8*N-1:0] ops_i,
  output logic [N+2:0]   sum_o
);

  logic [N:0]   l1 [4];
  logic [N+1:0] l2 [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l1[i] = {1'b0, ops_i[(2*i)*N +: N]} + {1'b0, ops_i[(2*i+1)*N +: N]};
    end
    for (int i = 0; i < 2; i++) begin
      l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    end
    sum_o = {1'b0, l2[0]} + {1'b0, l2[1]};
  end

endmodule

// File: rtl/tree_sum_sequencer.sv
// Packs a streamed job into 8-operand groups, reduces each group through tree_sum8
// and accumulates the group sums into a wide total presented on a valid/ready output.
module tree_sum_sequencer
  import tree_sum_sequencer_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = N + CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [N-1:0]     in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [ACC_W-1:0] out_sum_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  state_e                  state_q, state_d;
  logic [SlotIdxW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [TreeFanin*N-1:0]  slots_q, slots_d;
  logic [N+2:0]            tree_sum;

  tree_sum8 #(
    .N (N)
  ) u_tree (
    .ops_i (slots_q),
    .sum_o (tree_sum)
  );

  assign in_ready_o  = (state_q == StLoad);
  assign out_valid_o = (state_q == StDone);
  assign out_sum_o   = acc_q;
  assign busy_o      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    slots_d = slots_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rem_d   = len_i;
          acc_d   = '0;
          slots_d = '0;
          idx_d   = '0;
          state_d = (len_i == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          slots_d[32'(idx_q)*N +: N] = in_data_i;
          idx_d = idx_q + SlotIdxW'(1);
          rem_d = rem_q - CNT_W'(1);
          // Launch on a full group or on the last operand of the job.
          if (idx_q == SlotIdxW'(TreeFanin - 1) || rem_q == CNT_W'(1)) begin
            state_d = StSum;
          end
        end
      end
      StSum: begin
        acc_d   = acc_q + ACC_W'(tree_sum);
        slots_d = '0;
        idx_d   = '0;
        state_d = (rem_q != '0) ? StLoad : StDone;
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      slots_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      slots_q <= slots_d;
    end
  end

endmodule

// File: tb/tb_tree_sum_sequencer.sv
// Directed bench for tree_sum_sequencer with hand-computed expected totals and latencies.
module tb_tree_sum_sequencer;

  localparam int unsigned N     = 64;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = N + CNT_W;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] len_i = '0;
  logic             in_valid_i = 1'b0;
  logic [N-1:0]     in_data_i = '0;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [ACC_W-1:0] out_sum_o;
  logic             out_ready_i = 1'b0;
  logic             busy_o;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] ops [0:31];

  // Results of the last drive_job call.
  int               r_cycle;
  int               r_sums;
  bit               r_ever_ready;
  bit               r_busy_ok;
  logic [ACC_W-1:0] r_sum;

  always #5 clk_i = ~clk_i;

  tree_sum_sequencer #(
    .N     (N),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .len_i       (len_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_sum_o   (out_sum_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  // Called at #1 after an edge with the DUT idle; returns when out_valid is seen or on timeout.
  task automatic drive_job(input int len, input bit gaps, input bit poke_start);
    int  k;
    bit  xfer;
    k = 0;
    r_sums = 0;
    r_ever_ready = 1'b0;
    r_busy_ok = 1'b1;
    start_i = 1'b1;
    len_i = CNT_W'(len);
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    r_cycle = 1;
    while (!out_valid_o && r_cycle < 200) begin
      if (!busy_o) r_busy_ok = 1'b0;
      if (in_ready_o) r_ever_ready = 1'b1;
      if (busy_o && !in_ready_o) r_sums++;
      in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data_i = ops[k < 32 ? k : 31];
      start_i = poke_start && (r_cycle == 3);
      len_i = start_i ? CNT_W'(1) : CNT_W'(len);
      xfer = in_ready_o && in_valid_i;
      @(posedge clk_i);
      #1;
      if (xfer) k++;
      r_cycle++;
    end
    start_i = 1'b0;
    in_valid_i = 1'b0;
    r_sum = out_sum_o;
  endtask

  task automatic consume();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_o); end
    total++; if (out_sum_o !== '0) begin bad++; $display("FAIL reset_out_sum got=%0h want=0", out_sum_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_full_group();
    for (int i = 0; i < 8; i++) ops[i] = N'(i + 1);
    drive_job(8, 1'b0, 1'b0);
    total++; if (r_cycle !== 10) begin bad++; $display("FAIL full_latency got=%0d want=10", r_cycle); end
    total++; if (r_sum !== ACC_W'(36)) begin bad++; $display("FAIL full_sum got=%0h want=24", r_sum); end
    total++; if (r_busy_ok !== 1'b1) begin bad++; $display("FAIL full_busy got=0 want=1"); end
    total++; if (r_sums !== 1) begin bad++; $display("FAIL full_sum_count got=%0d want=1", r_sums); end
    consume();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL full_drop_valid got=%b want=0", out_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL full_idle_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_partial();
    // Preceding job leaves nonzero values 1..8 behind; a fresh job must not see them.
    ops[0] = 64'd5; ops[1] = 64'd6; ops[2] = 64'd7;
    for (int i = 3; i < 8; i++) ops[i] = 64'hDEAD;
    drive_job(3, 1'b0, 1'b0);
    total++; if (r_sum !== ACC_W'(18)) begin bad++; $display("FAIL partial_sum got=%0h want=12", r_sum); end
    total++; if (r_cycle !== 5) begin bad++; $display("FAIL partial_latency got=%0d want=5", r_cycle); end
    consume();
  endtask

  task automatic test_zero_len();
    drive_job(0, 1'b0, 1'b0);
    total++; if (r_cycle !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", r_cycle); end
    total++; if (r_sum !== '0) begin bad++; $display("FAIL zero_sum got=%0h want=0", r_sum); end
    total++; if (r_ever_ready !== 1'b0) begin bad++; $display("FAIL zero_in_ready got=1 want=0"); end
    consume();
  endtask

  task automatic test_multi_max();
    logic [ACC_W-1:0] exp_sum;
    exp_sum = 80'h13_FFFF_FFFF_FFFF_FFEC;
    for (int i = 0; i < 32; i++) ops[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_job(20, 1'b0, 1'b0);
    total++; if (r_sum !== exp_sum) begin bad++; $display("FAIL multi_sum got=%0h want=%0h", r_sum, exp_sum); end
    total++; if (r_sums !== 3) begin bad++; $display("FAIL multi_sum_count got=%0d want=3", r_sums); end
    total++; if (r_cycle !== 24) begin bad++; $display("FAIL multi_latency got=%0d want=24", r_cycle); end
    consume();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 11; i++) ops[i] = N'(10 * (i + 1));
    drive_job(11, 1'b1, 1'b0);
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b want=1", out_valid_o); end
    total++; if (r_sum !== ACC_W'(660)) begin bad++; $display("FAIL gaps_sum got=%0d want=660", r_sum); end
    consume();
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) ops[i] = N'(i + 1);
    drive_job(8, 1'b0, 1'b1);
    total++; if (r_sum !== ACC_W'(36)) begin bad++; $display("FAIL start_ign_sum got=%0d want=36", r_sum); end
    total++; if (r_cycle !== 10) begin bad++; $display("FAIL start_ign_latency got=%0d want=10", r_cycle); end
    consume();
  endtask

  task automatic test_out_stall();
    ops[0] = 64'd100; ops[1] = 64'd200;
    drive_job(2, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=1", c, out_valid_o); end
      total++; if (out_sum_o !== ACC_W'(300)) begin bad++; $display("FAIL stall_sum cyc=%0d got=%0d want=300", c, out_sum_o); end
    end
    // start coinciding with the result transfer is ignored.
    start_i = 1'b1;
    len_i = CNT_W'(1);
    consume();
    start_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL done_start_busy got=%b want=0", busy_o); end
    @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL done_start_busy2 got=%b want=0", busy_o); end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1;
    len_i = CNT_W'(10);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_i = N'(50 + i);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b want=0", in_ready_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid_o); end
    total++; if (out_sum_o !== '0) begin bad++; $display("FAIL mid_out_sum got=%0h want=0", out_sum_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy_o); end
    rst_ni = 1'b1;
    ops[0] = 64'd3; ops[1] = 64'd4;
    drive_job(2, 1'b0, 1'b0);
    total++; if (r_sum !== ACC_W'(7)) begin bad++; $display("FAIL mid_fresh_sum got=%0d want=7", r_sum); end
    total++; if (r_cycle !== 4) begin bad++; $display("FAIL mid_fresh_latency got=%0d want=4", r_cycle); end
    consume();
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_partial();
    test_zero_len();
    test_multi_max();
    test_gaps();
    test_start_ignored();
    test_out_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
